led_blink_driver: RTL and testbench
===================================

// Module: led_blink_driver
// PURPOSE
//  Output-side counterpart to the push-button debouncer. It turns single-cycle
//  event pulses into human-visible LED blinks.
//  - Each pulse_in is queued.
//  - Each queued event produces exactly one blink: ON_TICKS ticks lit, then
//    OFF_TICKS ticks dark.
//  - N presses give N distinct blinks.
//  Sits between debounced button/event logic and board LED pins. All logic runs
//  on clk using a tick enable; no derived clocks.
// PARAMETERS
//  CLK_DIV    250000  clk cycles per tick (2.5 ms at 100 MHz); >= 2
//  ON_TICKS   40      ticks LED is lit per blink; >= 1
//  OFF_TICKS  40      ticks LED is dark after each blink; >= 1
//  PEND_W     4       width of pending-event counter; saturates at 2**PEND_W-1
// PORTS
//  clk       in   1       system clock
//  rst_n     in   1       synchronous reset, active-low
//  pulse_in  in   1       1-cycle event request (e.g. debouncer output)
//  led_out   out  1       registered LED drive, 1 = lit
//  busy      out  1       1 while state != IDLE
//  pending   out  PEND_W  queued events not yet started
//  overflow  out  1       1-cycle flag: a pulse_in was dropped (counter full)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, led_out=0, busy=0, pending=0,
//   overflow=0, prescaler=0, tick counter=0. Reset mid-blink aborts it and
//   discards the queue. pulse_in is ignored while rst_n=0.
//  Prescaler: counts 0..CLK_DIV-1. tick=1 in the cycle count==CLK_DIV-1.
//   Count is forced to 0 in the cycle any ON or OFF phase is entered, so every
//   phase lasts exactly ticks*CLK_DIV cycles. Prescaler holds 0 in IDLE.
//  consume: start=1 in IDLE, or at the final OFF tick, when (pending!=0 or
//   pulse_in).
//  Pending counter:
//   inc = pulse_in & ~(pending==MAX & ~consume)
//   dec = consume & (pending!=0)
//   A pulse_in arriving while pending==0 at consume is used directly:
//   no inc, no dec.
//   pending_next = pending + inc - dec; never wraps.
//   overflow_next = pulse_in & (pending==MAX) & ~consume.
//  FSM (led_state_t):
//   IDLE: start -> ON, led_out=1 next cycle. pulse_in at cycle N gives
//    led_out=1 at N+1.
//   ON:   count ticks. At tick #ON_TICKS -> OFF, led_out=0 next cycle.
//   OFF:  count ticks. At tick #OFF_TICKS, start -> ON (back-to-back,
//    consume), else -> IDLE.
//   pulse_in during ON/OFF only queues; it never shortens or extends a phase.
//  Tick counter width: $clog2(max(ON_TICKS,OFF_TICKS)+1); cleared on phase
//   entry.
//  All outputs are registered. busy is decoded from the registered state.
// STRUCTURE
//  Package led_blink_pkg holds typedef enum logic [1:0] led_state_t
//   {LB_IDLE, LB_ON, LB_OFF}.
//  Sub-module tick_prescaler: params DIV; ports clk, rst_n, restart, tick.
//   One instance.
//  Top holds FSM, tick counter, pending counter and output registers.
// TESTING (bench params CLK_DIV=4, ON_TICKS=2, OFF_TICKS=3, PEND_W=2)
//  1 Hold rst_n=0 for 3 cycles with pulse_in=1 -> led_out=busy=overflow=0,
//    pending=0 throughout.
//  2 Single pulse at cycle 10 -> led_out=1 cycles 11..18, 0 from 19; busy=1
//    cycles 11..30, 0 at 31; pending stays 0.
//  3 Pulses at cycles 10,11,12 -> pending 1 at 12, 2 at 13. Three blinks
//    starting 11, 31, 51, with no IDLE between them. pending drops 2->1 at 31
//    and 1->0 at 51.
//  4 Six pulses during first ON phase -> pending saturates at 3. overflow=1
//    for one cycle after each of the 5th and 6th. Then exactly 4 blinks total.
//  5 pulse_in in the exact cycle of the final OFF tick with pending=1 ->
//    next blink starts; pending stays 1 (inc and dec cancel).
//  6 rst_n=0 at cycle 14 of test 3 -> cycle 15: led_out=0, busy=0, pending=0.
//    No blink after reset release until a new pulse_in.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink driver.
package led_blink_pkg;

    typedef enum logic [1:0] {
        LB_IDLE = 2'd0,
        LB_ON   = 2'd1,
        LB_OFF  = 2'd2
    } led_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider producing a one-cycle tick every DIV cycles.
module tick_prescaler #(
    parameter int DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    // restart realigns the phase so a new LED phase always gets full-length ticks
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/led_blink_driver.sv
// Converts single-cycle event pulses into queued, fixed-length LED blinks.
module led_blink_driver
    import led_blink_pkg::*;
#(
    parameter int CLK_DIV   = 250000,
    parameter int ON_TICKS  = 40,
    parameter int OFF_TICKS = 40,
    parameter int PEND_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TCW = $clog2(max2(ON_TICKS, OFF_TICKS) + 1);

    led_state_t     state;
    logic [TCW-1:0] tick_cnt;
    logic           tick;
    logic           last_on;
    logic           last_off;
    logic           consume;
    logic           full;
    logic           inc;
    logic           dec;
    logic           restart;

    assign last_on  = (state == LB_ON)  && tick && (tick_cnt == TCW'(ON_TICKS - 1));
    assign last_off = (state == LB_OFF) && tick && (tick_cnt == TCW'(OFF_TICKS - 1));
    assign consume  = ((state == LB_IDLE) || last_off) && ((pending != '0) || pulse_in);
    assign full     = &pending;
    // A pulse arriving with an empty queue at consume is used directly: no inc, no dec
    assign inc      = pulse_in & ~(full & ~consume) & ~(consume & (pending == '0));
    assign dec      = consume & (pending != '0);
    assign restart  = (state == LB_IDLE) | consume | last_on;

    tick_prescaler #(
        .DIV(CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LB_IDLE;
            led_out  <= 1'b0;
            tick_cnt <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= pulse_in & full & ~consume;

            case ({inc, dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase

            unique case (state)
                LB_IDLE: begin
                    if (consume) begin
                        state    <= LB_ON;
                        led_out  <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                LB_ON: begin
                    if (last_on) begin
                        state    <= LB_OFF;
                        led_out  <= 1'b0;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                LB_OFF: begin
                    if (last_off) begin
                        tick_cnt <= '0;
                        if (consume) begin
                            state   <= LB_ON;
                            led_out <= 1'b1;
                        end else begin
                            state   <= LB_IDLE;
                        end
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= LB_IDLE;
                    led_out  <= 1'b0;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state != LB_IDLE);

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: directed timing scenarios plus randomized pulses vs a blink-timeline model.
module tb_led_blink_driver;

    localparam int CLK_DIV   = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 3;
    localparam int PEND_W    = 2;
    localparam int PMAX      = (1 << PEND_W) - 1;
    localparam int ON_CYC    = ON_TICKS * CLK_DIV;
    localparam int BLINK_CYC = (ON_TICKS + OFF_TICKS) * CLK_DIV;
    localparam int NH        = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pulse_in = 1'b0;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model: is a blink in progress, and which cycle of the blink is this
    bit m_active;
    int m_pos;
    int m_pend;
    bit m_ovf;

    bit pulse_at [NH];
    bit obs_led  [NH];
    bit obs_busy [NH];
    int obs_pend [NH];
    bit obs_ovf  [NH];

    led_blink_driver #(
        .CLK_DIV  (CLK_DIV),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .PEND_W   (PEND_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_update(input logic r, input logic p);
        bit eob, consume;
        if (!r) begin
            m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
        end else begin
            eob     = m_active && (m_pos == BLINK_CYC - 1);
            consume = (!m_active || eob) && (m_pend != 0 || p);
            m_ovf   = !consume && p && (m_pend == PMAX);
            if (consume) begin
                if (m_pend != 0) m_pend = m_pend - 1 + (p ? 1 : 0);
            end else if (p && m_pend < PMAX) begin
                m_pend = m_pend + 1;
            end
            if (consume) begin
                m_active = 1; m_pos = 0;
            end else if (eob) begin
                m_active = 0; m_pos = 0;
            end else if (m_active) begin
                m_pos++;
            end
        end
    endtask

    task automatic step(input int c, input logic r, input logic p);
        rst_n    = r;
        pulse_in = p;
        @(negedge clk);
        if (chk_en) begin
            chk("led",      32'(led_out),  32'(m_active && m_pos < ON_CYC));
            chk("busy",     32'(busy),     32'(m_active));
            chk("pending",  32'(pending),  32'(m_pend));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
        if (c >= 0 && c < NH) begin
            obs_led[c]  = led_out;
            obs_busy[c] = busy;
            obs_pend[c] = int'(pending);
            obs_ovf[c]  = overflow;
        end
        @(posedge clk);
        model_update(r, p);
        #1;
    endtask

    task automatic run_scn(input int n, input int rst_cyc);
        step(-1, 1'b0, 1'b0);
        for (int c = 0; c < n; c++) step(c, (c == rst_cyc) ? 1'b0 : 1'b1, pulse_at[c]);
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < NH; i++) pulse_at[i] = 0;
    endtask

    function automatic int count_blinks(input int n);
        int k = 0;
        for (int i = 1; i < n; i++) if (obs_led[i] && !obs_led[i-1]) k++;
        return k;
    endfunction

    initial begin
        int s;
        m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;

        // Test 1: reset held with pulse_in asserted
        step(-1, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(-1, 1'b0, 1'b1);
        step(-1, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_led", 32'(led_out), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_pend", 32'(pending), 0);
        chk("t1_ovf", 32'(overflow), 0);

        // Test 2: single pulse
        clear_pulses(); pulse_at[10] = 1;
        run_scn(40, -1);
        chk("t2_led10", 32'(obs_led[10]), 0);
        chk("t2_led11", 32'(obs_led[11]), 1);
        chk("t2_led18", 32'(obs_led[18]), 1);
        chk("t2_led19", 32'(obs_led[19]), 0);
        chk("t2_busy30", 32'(obs_busy[30]), 1);
        chk("t2_busy31", 32'(obs_busy[31]), 0);
        s = 0; for (int i = 0; i < 40; i++) s += obs_pend[i];
        chk("t2_pend_zero", 32'(s), 0);

        // Test 3: three back-to-back pulses
        clear_pulses(); pulse_at[10] = 1; pulse_at[11] = 1; pulse_at[12] = 1;
        run_scn(80, -1);
        chk("t3_pend12", 32'(obs_pend[12]), 1);
        chk("t3_pend13", 32'(obs_pend[13]), 2);
        chk("t3_pend30", 32'(obs_pend[30]), 2);
        chk("t3_pend31", 32'(obs_pend[31]), 1);
        chk("t3_pend51", 32'(obs_pend[51]), 0);
        chk("t3_led31", 32'(obs_led[31]), 1);
        chk("t3_led51", 32'(obs_led[51]), 1);
        s = 0; for (int i = 11; i <= 70; i++) s += obs_busy[i];
        chk("t3_no_idle", 32'(s), 60);
        chk("t3_busy71", 32'(obs_busy[71]), 0);
        chk("t3_blinks", 32'(count_blinks(80)), 3);

        // Test 4: six pulses, queue saturates
        clear_pulses(); for (int i = 10; i < 16; i++) pulse_at[i] = 1;
        run_scn(110, -1);
        chk("t4_pend14", 32'(obs_pend[14]), 3);
        chk("t4_ovf15", 32'(obs_ovf[15]), 1);
        chk("t4_ovf16", 32'(obs_ovf[16]), 1);
        s = 0; for (int i = 0; i < 110; i++) s += obs_ovf[i];
        chk("t4_ovf_count", 32'(s), 2);
        chk("t4_blinks", 32'(count_blinks(110)), 4);

        // Test 5: pulse on the final OFF tick with pending=1
        clear_pulses(); pulse_at[10] = 1; pulse_at[11] = 1; pulse_at[30] = 1;
        run_scn(80, -1);
        chk("t5_pend30", 32'(obs_pend[30]), 1);
        chk("t5_pend31", 32'(obs_pend[31]), 1);
        chk("t5_led31", 32'(obs_led[31]), 1);
        chk("t5_pend51", 32'(obs_pend[51]), 0);
        chk("t5_blinks", 32'(count_blinks(80)), 3);

        // Test 6: reset during test 3
        clear_pulses(); pulse_at[10] = 1; pulse_at[11] = 1; pulse_at[12] = 1;
        run_scn(70, 14);
        chk("t6_led15", 32'(obs_led[15]), 0);
        chk("t6_busy15", 32'(obs_busy[15]), 0);
        chk("t6_pend15", 32'(obs_pend[15]), 0);
        s = 0; for (int i = 15; i < 70; i++) s += obs_led[i] + obs_busy[i];
        chk("t6_quiet", 32'(s), 0);

        // Randomized pulses at several densities, occasional reset
        foreach (pulse_at[i]) pulse_at[i] = 0;
        for (int blk = 0; blk < 4; blk++) begin
            int dens;
            dens = (blk == 0) ? 3 : (blk == 1) ? 10 : (blk == 2) ? 30 : 70;
            for (int c = 0; c < 600; c++) begin
                step(-1, ($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 99) < dens));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
